// File: rtl/ipp_debug_pkg.sv
// ipp_debug_pkg: jdo field layout, control-register bits and shared types
// for the Nios II debug-side OCI memory.
package ipp_debug_pkg;

  localparam int JDO_W        = 38;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_ADDR_LSB = 18;
  localparam int JDO_RD_BIT   = 17;
  localparam int JDO_GO_BIT   = 16;

  localparam int CTRL_READY_BIT = 0;
  localparam int CTRL_ERROR_BIT = 1;
  localparam int CTRL_GO_BIT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DBG_RD,
    ST_CPU_RD
  } ocimemState_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_WRITE,
    CMD_READ
  } dbgCmd_e;

  // Collapse the three debug strobes into one command, ocimem_a first,
  // then ocimem_b, then no_action_a; lower-priority strobes are dropped.
  function automatic dbgCmd_e pickCmd(logic actA, logic actB, logic noActA);
    dbgCmd_e cmd;
    cmd = CMD_NONE;
    if (actA) begin
      cmd = CMD_LOAD;
    end else if (actB) begin
      cmd = CMD_WRITE;
    end else if (noActA) begin
      cmd = CMD_READ;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/ipp_debug_ociram.sv
// ipp_debug_ociram: single-port synchronous RAM, 32-bit words, byte-enabled
// writes and a registered read port with one cycle of latency.
module ipp_debug_ociram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Byte-masked write when enabled for write, otherwise register the read word
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) begin
            mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
          end
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/ipp_debug_ocimem.sv
// ipp_debug_ocimem: debug-side OCI RAM plus monitor handshake flags, shared
// with a CPU slave port. Debug commands win the RAM; a debug strobe that
// arrives while a read is in flight waits in a one-entry pending slot.
module ipp_debug_ocimem
  import ipp_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go
);

  ocimemState_e      state_q, state_d;
  logic [ADDR_W-1:0] monAReg_q, monAReg_d;
  logic [31:0]       monDReg_q, monDReg_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              go_q, go_d;
  logic              pendValid_q, pendValid_d;
  dbgCmd_e           pendCmd_q, pendCmd_d;
  logic [JDO_W-1:0]  pendJdo_q, pendJdo_d;

  dbgCmd_e           strobeCmd;
  dbgCmd_e           serveCmd;
  logic [JDO_W-1:0]  serveJdo;
  logic [ADDR_W-1:0] jdoAddr;
  logic              ctrlSel;
  logic [31:0]       ctrlWord;
  logic              cpuWait;
  logic [31:0]       cpuRdata;

  logic              ramEn, ramWe;
  logic [3:0]        ramBe;
  logic [ADDR_W-1:0] ramAddr;
  logic [31:0]       ramWdata, ramRdata;

  logic              unusedJdo;

  assign strobeCmd = pickCmd(take_action_ocimem_a, take_action_ocimem_b,
                             take_no_action_ocimem_a);
  assign ctrlSel   = cpu_address[ADDR_W];
  assign jdoAddr   = serveJdo[JDO_ADDR_LSB +: ADDR_W];
  assign unusedJdo = ^{serveJdo[JDO_W-1:JDO_DATA_MSB+1], serveJdo[JDO_DATA_LSB-1:0]};

  // Control register image as the CPU reads it
  always_comb begin
    ctrlWord = '0;
    ctrlWord[CTRL_READY_BIT] = ready_q;
    ctrlWord[CTRL_ERROR_BIT] = error_q;
    ctrlWord[CTRL_GO_BIT]    = go_q;
  end

  // Arbitration, RAM port steering, flag updates and next state
  always_comb begin
    state_d     = state_q;
    monAReg_d   = monAReg_q;
    monDReg_d   = monDReg_q;
    ready_d     = ready_q;
    error_d     = error_q;
    go_d        = go_q;
    pendValid_d = pendValid_q;
    pendCmd_d   = pendCmd_q;
    pendJdo_d   = pendJdo_q;
    serveCmd    = CMD_NONE;
    serveJdo    = jdo;
    ramEn       = 1'b0;
    ramWe       = 1'b0;
    ramBe       = '0;
    ramAddr     = monAReg_q;
    ramWdata    = '0;
    cpuWait     = 1'b1;
    cpuRdata    = '0;

    case (state_q)
      ST_IDLE: begin
        if (pendValid_q) begin
          serveCmd    = pendCmd_q;
          serveJdo    = pendJdo_q;
          pendValid_d = 1'b0;
          if (strobeCmd != CMD_NONE) begin
            pendValid_d = 1'b1;
            pendCmd_d   = strobeCmd;
            pendJdo_d   = jdo;
          end
        end else begin
          serveCmd = strobeCmd;
        end

        case (serveCmd)
          CMD_LOAD: begin
            monAReg_d = jdoAddr;
            if (serveJdo[JDO_RD_BIT]) begin
              ramEn   = 1'b1;
              ramAddr = jdoAddr;
              state_d = ST_DBG_RD;
            end
            if (serveJdo[JDO_GO_BIT]) begin
              go_d    = 1'b1;
              ready_d = 1'b0;
              error_d = 1'b0;
            end
          end
          CMD_WRITE: begin
            ramEn     = 1'b1;
            ramWe     = 1'b1;
            ramBe     = 4'hF;
            ramWdata  = serveJdo[JDO_DATA_MSB:JDO_DATA_LSB];
            monAReg_d = monAReg_q + ADDR_W'(1);
          end
          CMD_READ: begin
            ramEn     = 1'b1;
            monAReg_d = monAReg_q + ADDR_W'(1);
            state_d   = ST_DBG_RD;
          end
          default: begin
            if (cpu_write) begin
              cpuWait = 1'b0;
              if (ctrlSel) begin
                if (cpu_byteenable[0]) begin
                  ready_d = cpu_writedata[0];
                  error_d = cpu_writedata[1];
                  if (cpu_writedata[0]) begin
                    go_d = 1'b0;
                  end
                end
              end else begin
                ramEn    = 1'b1;
                ramWe    = 1'b1;
                ramBe    = cpu_byteenable;
                ramAddr  = cpu_address[ADDR_W-1:0];
                ramWdata = cpu_writedata;
              end
            end else if (cpu_read) begin
              if (ctrlSel) begin
                cpuWait  = 1'b0;
                cpuRdata = ctrlWord;
              end else begin
                ramEn   = 1'b1;
                ramAddr = cpu_address[ADDR_W-1:0];
                state_d = ST_CPU_RD;
              end
            end
          end
        endcase
      end

      ST_DBG_RD: begin
        monDReg_d = ramRdata;
        state_d   = ST_IDLE;
        if (!pendValid_q && strobeCmd != CMD_NONE) begin
          pendValid_d = 1'b1;
          pendCmd_d   = strobeCmd;
          pendJdo_d   = jdo;
        end
      end

      ST_CPU_RD: begin
        cpuWait  = 1'b0;
        cpuRdata = ramRdata;
        state_d  = ST_IDLE;
        if (!pendValid_q && strobeCmd != CMD_NONE) begin
          pendValid_d = 1'b1;
          pendCmd_d   = strobeCmd;
          pendJdo_d   = jdo;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, address, data, flag and pending-slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      monAReg_q   <= '0;
      monDReg_q   <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      go_q        <= 1'b0;
      pendValid_q <= 1'b0;
      pendCmd_q   <= CMD_NONE;
      pendJdo_q   <= '0;
    end else begin
      state_q     <= state_d;
      monAReg_q   <= monAReg_d;
      monDReg_q   <= monDReg_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      go_q        <= go_d;
      pendValid_q <= pendValid_d;
      pendCmd_q   <= pendCmd_d;
      pendJdo_q   <= pendJdo_d;
    end
  end

  ipp_debug_ociram #(.ADDR_W(ADDR_W)) u_ociram (
    .clk_i   (clk),
    .en_i    (ramEn),
    .we_i    (ramWe),
    .be_i    (ramBe),
    .addr_i  (ramAddr),
    .wdata_i (ramWdata),
    .rdata_o (ramRdata)
  );

  assign cpu_waitrequest = reset ? 1'b1 : cpuWait;
  assign cpu_readdata    = reset ? 32'h0 : cpuRdata;
  assign MonDReg         = monDReg_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = error_q;
  assign monitor_go      = go_q;

endmodule

// File: doc/ipp_debug_ocimem.md
# ipp_debug_ocimem

Debug-side on-chip memory and monitor handshake for each Nios II processor in the image parallel-processing system. It sits directly downstream of the per-processor debug-slave wrapper. It consumes that wrapper's system-clock `jdo` word and `take_*_ocimem_*` strobes, and returns `MonDReg`, `monitor_ready` and `monitor_error` to it. It also arbitrates a CPU-side slave port onto the same RAM, so debug writes and reads and CPU monitor-code accesses share one memory.

## Interface
- `ADDR_W`, 8: word-address width of the OCI RAM, giving 2^ADDR_W 32-bit words.
- `clk`  in  1  system clock, the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `jdo`  in  38  debug command/data word from the debug-slave wrapper.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address and control.
- `take_action_ocimem_b`  in  1  one-cycle strobe: debug write, then increment.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: debug read, then increment.
- `cpu_address`  in  ADDR_W+1  bit ADDR_W = 1 selects the control register; otherwise a RAM word.
- `cpu_read`, `cpu_write`  in  1  CPU access requests.
- `cpu_writedata`  in  32  CPU write data.
- `cpu_byteenable`  in  4  CPU byte enables.
- `cpu_readdata`  out  32  CPU read data.
- `cpu_waitrequest`  out  1  CPU stall.
- `MonDReg`  out  32  debug read-data register.
- `monitor_ready`, `monitor_error`, `monitor_go`  out  1  monitor handshake flags.

## Operation
- Address register `MonAReg[ADDR_W-1:0]` is the debug-side address. Increments wrap from 2^ADDR_W-1 to 0.
- `take_action_ocimem_a`:
  - `MonAReg <= jdo[18 +: ADDR_W]`.
  - If `jdo[17]` = 1, queue a debug read at the new address.
  - If `jdo[16]` = 1, set `monitor_go` and clear `monitor_ready` and `monitor_error`.
- `take_action_ocimem_b`: write `jdo[34:3]` to `RAM[MonAReg]` with all bytes enabled. Then `MonAReg++`.
- `take_no_action_ocimem_a`: read `RAM[MonAReg]` into `MonDReg`. Then `MonAReg++`.
- Strobe priority: if more than one strobe is high in a cycle, only one is served, in the order ocimem_a > ocimem_b > no_action_a. The others are dropped.
- Control register, CPU access only:
  - Read returns {29'b0, go, error, ready}.
  - A write with byteenable[0] = 1 sets ready and error to wdata[0] and wdata[1], and clears go when wdata[0] = 1.
- FSM states:
  - IDLE: accepts debug strobes and CPU accesses.
  - DBG_RD: RAM read issued; next edge loads `MonDReg`, then back to IDLE.
  - CPU_RD: RAM read issued; next cycle presents `cpu_readdata` with waitrequest low, then back to IDLE.
- Arbitration: debug has priority.
  - A debug strobe arriving in any non-IDLE state is latched in a one-entry pending slot and served on return to IDLE.
  - A second strobe while the slot is full is dropped.
  - A CPU access in the same cycle as a served debug strobe sees `cpu_waitrequest` = 1 and is retried.
- CPU RAM writes obey byte enables.
- Reset mid-operation: all registers return to their reset values immediately and any pending debug command is discarded. RAM contents are undefined after reset.

## Timing
- Reset values:
  - `MonDReg`, `MonAReg` = 0.
  - `monitor_ready`, `monitor_error`, `monitor_go` = 0.
  - `cpu_readdata` = 0.
  - FSM in IDLE, pending slot empty.
  - `cpu_waitrequest` = 1 while reset is asserted.
- Debug write: the RAM word and `MonAReg++` update on the edge ending the strobe cycle.
- Debug read: the strobe in cycle N issues the RAM read. `MonDReg` is valid after edge N+1, and the FSM is back in IDLE in cycle N+2.
- CPU write to RAM or control: completes in 1 cycle when uncontended (`cpu_waitrequest` = 0).
- CPU read:
  - Cycle 1 has `cpu_waitrequest` = 1.
  - Cycle 2 has `cpu_waitrequest` = 0 with `cpu_readdata` valid.
  - A control-register read takes 1 cycle with no wait.
- Flag updates from either side are visible on the next cycle. If a debug `jdo[16]` strobe and a CPU control write land in the same cycle, the debug strobe wins.

## Structure
- Package `ipp_debug_pkg` holds:
  - jdo field constants: data [34:3], addr base 18, read flag 17, go flag 16.
  - The FSM state enum.
  - Control-register bit positions.
- One sub-module, `ipp_debug_ociram`: single-port synchronous RAM with byte enables and 1-cycle read latency.

## Test plan
- Debug write/read round-trip: ocimem_a with addr 0x10, then ocimem_b with data 0xDEADBEEF, then ocimem_a with addr 0x10 and `jdo[17]` = 1 → `MonDReg` = 0xDEADBEEF two cycles after the last strobe; `MonAReg` = 0x10.
- Address wrap: ocimem_a with addr 0xFF, then two ocimem_b writes of 0x1 and 0x2 → RAM[0xFF] = 1, RAM[0x00] = 2, `MonAReg` = 0x01.
- Go handshake: ocimem_a with `jdo[16]` = 1 → go = 1, ready = 0. CPU writes control 0x1 → ready = 1, go = 0. CPU reads control → 0x1.
- Contention: CPU read of word 5 in the same cycle as an ocimem_b strobe → CPU sees waitrequest for 2 cycles, then readdata = the new value at word 5 if `MonAReg` = 5.
- Byte enables: CPU writes 0xAABBCCDD to word 3 with be = 4'b0101 over 0x0 → a debug read of word 3 returns 0x00BB00DD.
- Async reset asserted during DBG_RD → `MonDReg` = 0 and all flags = 0 immediately; a strobe issued before reset produces no effect afterward.
